// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: paddles, ball, scores and game state, advanced once per frame_tick.
// Define PONG_SPEEDUP_EN to make the ball speed up by one pixel per paddle hit.
module pong_game_ctrl #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int PADDLE_H     = 64,
  parameter int PADDLE_W     = 8,
  parameter int PADDLE_X1    = 16,
  parameter int PADDLE_X2    = 616,
  parameter int BALL_SIZE    = 8,
  parameter int PADDLE_STEP  = 4,
  parameter int BALL_STEP    = 2,
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        p1_up,
  input  logic        p1_down,
  input  logic        p2_up,
  input  logic        p2_down,
  output logic [11:0] paddle_1,
  output logic [11:0] paddle_2,
  output logic [11:0] ball_x,
  output logic [11:0] ball_y,
  output logic [3:0]  score_1,
  output logic [3:0]  score_2,
  output logic [2:0]  state,
  output logic [1:0]  winner
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_SERVE = 3'd1, S_PLAY = 3'd2, S_POINT = 3'd3, S_OVER = 3'd4
  } state_t;

  localparam int CW = $clog2(SERVE_FRAMES);
  localparam logic [11:0] PAD_MID  = 12'((V_ACTIVE - PADDLE_H) / 2);
  localparam logic [11:0] BALL_X0  = 12'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [11:0] BALL_Y0  = 12'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [11:0] HIT_L_X  = 12'(PADDLE_X1 + PADDLE_W);
  localparam logic [11:0] HIT_R_X  = 12'(PADDLE_X2 - BALL_SIZE);
  localparam logic [11:0] BALL_YMX = 12'(V_ACTIVE - BALL_SIZE);
  localparam logic signed [12:0] PMAX_S  = 13'(V_ACTIVE - PADDLE_H);
  localparam logic signed [12:0] PSTEP_S = 13'(PADDLE_STEP);
  localparam logic signed [12:0] BS_S    = 13'(BALL_SIZE);
  localparam logic signed [12:0] PH_S    = 13'(PADDLE_H);
  localparam logic signed [12:0] LP_S    = 13'(PADDLE_X1 + PADDLE_W);
  localparam logic signed [12:0] RP_S    = 13'(PADDLE_X2);
  localparam logic signed [12:0] H_S     = 13'(H_ACTIVE);
  localparam logic signed [12:0] V_S     = 13'(V_ACTIVE);

  state_t             fsm;
  logic               dx, dy, start_prev, start_pend, p1_scored, pend_now;
  logic [CW-1:0]      serve_cnt, serve_next;
  logic [3:0]         step, lead_score;
  logic signed [12:0] step_s, bx_s, by_s, p1_s, p2_s, nx, ny;
  logic               hit_l, hit_r, miss, wall_top, wall_bot;
  logic [11:0]        p1_next, p2_next;

  assign state = fsm;

  function automatic logic [11:0] move_paddle(input logic [11:0] p, input logic up, input logic dn);
    logic signed [12:0] t;
    t = $signed({1'b0, p});
    if (up && !dn)      t = t - PSTEP_S;
    else if (dn && !up) t = t + PSTEP_S;
    if (t < 13'sd0)        t = 13'sd0;
    else if (t > PMAX_S)   t = PMAX_S;
    return t[11:0];
  endfunction

`ifdef PONG_SPEEDUP_EN
  // Step is only consumed in PLAY, which is always entered through SERVE, so reloading outside PLAY is enough.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 step <= 4'(BALL_STEP);
    else if (fsm != S_PLAY)     step <= 4'(BALL_STEP);
    else if (frame_tick && (hit_l || hit_r) && step < 4'(2 * BALL_STEP))
      step <= step + 4'd1;
  end
`else
  assign step = 4'(BALL_STEP);
`endif

  always_comb begin
    pend_now   = start_pend | (start & ~start_prev);
    serve_next = serve_cnt + CW'(1);
    step_s     = $signed({9'd0, step});
    bx_s       = $signed({1'b0, ball_x});
    by_s       = $signed({1'b0, ball_y});
    p1_s       = $signed({1'b0, paddle_1});
    p2_s       = $signed({1'b0, paddle_2});
    nx         = dx ? bx_s + step_s : bx_s - step_s;
    ny         = dy ? by_s + step_s : by_s - step_s;
    hit_l      = !dx && (bx_s >= LP_S) && (nx <= LP_S) && (by_s + BS_S > p1_s) && (by_s < p1_s + PH_S);
    hit_r      = dx && (bx_s + BS_S <= RP_S) && (nx + BS_S >= RP_S) && (by_s + BS_S > p2_s) && (by_s < p2_s + PH_S);
    miss       = !hit_l && !hit_r && ((nx <= 13'sd0) || (nx + BS_S >= H_S));
    wall_top   = !dy && (ny <= 13'sd0);
    wall_bot   = dy && (ny + BS_S >= V_S);
    p1_next    = move_paddle(paddle_1, p1_up, p1_down);
    p2_next    = move_paddle(paddle_2, p2_up, p2_down);
    lead_score = p1_scored ? score_1 : score_2;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm <= S_IDLE; paddle_1 <= PAD_MID; paddle_2 <= PAD_MID;
      ball_x <= BALL_X0; ball_y <= BALL_Y0; dx <= 1'b1; dy <= 1'b1;
      score_1 <= 4'd0; score_2 <= 4'd0; winner <= 2'd0; serve_cnt <= '0;
      start_prev <= 1'b0; start_pend <= 1'b0; p1_scored <= 1'b0;
    end else begin
      start_prev <= start;
      // Every tick consumes the pending start, whether or not the current state acts on it.
      if (frame_tick)      start_pend <= 1'b0;
      else if (pend_now)   start_pend <= 1'b1;
      if (frame_tick) begin
        case (fsm)
          S_IDLE: if (pend_now) begin
            fsm <= S_SERVE; serve_cnt <= '0; score_1 <= 4'd0; score_2 <= 4'd0;
            dx <= 1'b1; dy <= 1'b1;
          end
          S_SERVE: begin
            paddle_1 <= p1_next; paddle_2 <= p2_next; serve_cnt <= serve_next;
            if (serve_next == CW'(SERVE_FRAMES - 1)) fsm <= S_PLAY;
          end
          S_PLAY: begin
            paddle_1 <= p1_next; paddle_2 <= p2_next;
            if (hit_l)       begin ball_x <= HIT_L_X; dx <= 1'b1; end
            else if (hit_r)  begin ball_x <= HIT_R_X; dx <= 1'b0; end
            else if (miss)   begin fsm <= S_POINT; p1_scored <= (nx > 13'sd0); end
            else             ball_x <= nx[11:0];
            if (!miss) begin
              if (wall_top)      begin ball_y <= 12'd0;    dy <= 1'b1; end
              else if (wall_bot) begin ball_y <= BALL_YMX; dy <= 1'b0; end
              else               ball_y <= ny[11:0];
            end
          end
          S_POINT: begin
            if (p1_scored) score_1 <= score_1 + 4'd1;
            else           score_2 <= score_2 + 4'd1;
            if (lead_score == 4'(WIN_SCORE - 1)) begin
              fsm <= S_OVER; winner <= p1_scored ? 2'd1 : 2'd2;
            end else begin
              // Serve heads toward the player who just lost the point.
              fsm <= S_SERVE; serve_cnt <= '0; ball_x <= BALL_X0; ball_y <= BALL_Y0;
              dx <= p1_scored; dy <= 1'b1;
            end
          end
          default: if (pend_now) begin
            fsm <= S_IDLE; score_1 <= 4'd0; score_2 <= 4'd0; winner <= 2'd0;
            paddle_1 <= PAD_MID; paddle_2 <= PAD_MID; ball_x <= BALL_X0; ball_y <= BALL_Y0;
            dx <= 1'b1; dy <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: directed scenarios plus random play against an integer game model.
module tb_pong_game_ctrl;
  localparam int PSTEP = 4, BSTEP = 2, WIN = 7, SERVE_N = 60, PMAX = 416;

  logic clk = 1'b0, reset = 1'b0, frame_tick = 1'b0, start = 1'b0;
  logic p1_up = 1'b0, p1_down = 1'b0, p2_up = 1'b0, p2_down = 1'b0;
  logic [11:0] paddle_1, paddle_2, ball_x, ball_y;
  logic [3:0]  score_1, score_2;
  logic [2:0]  state;
  logic [1:0]  winner;

  int n_assert = 0, n_fail = 0, n_tick = 0;
  int m_p1, m_p2, m_bx, m_by, m_s1, m_s2, m_st, m_win, m_cnt, m_step;
  bit m_dx, m_dy, m_pend, m_p1_scored;

  pong_game_ctrl dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
    .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
    .paddle_1(paddle_1), .paddle_2(paddle_2), .ball_x(ball_x), .ball_y(ball_y),
    .score_1(score_1), .score_2(score_2), .state(state), .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"}, state, m_st);
    chk({tag, ".paddle_1"}, paddle_1, m_p1);
    chk({tag, ".paddle_2"}, paddle_2, m_p2);
    chk({tag, ".ball_x"}, ball_x, m_bx);
    chk({tag, ".ball_y"}, ball_y, m_by);
    chk({tag, ".score_1"}, score_1, m_s1);
    chk({tag, ".score_2"}, score_2, m_s2);
    chk({tag, ".winner"}, winner, m_win);
  endtask

  task automatic model_reset();
    m_st = 0; m_p1 = 208; m_p2 = 208; m_bx = 316; m_by = 236; m_dx = 1; m_dy = 1;
    m_s1 = 0; m_s2 = 0; m_win = 0; m_cnt = 0; m_pend = 0; m_p1_scored = 0; m_step = BSTEP;
  endtask

  function automatic int mv(input int p, input bit up, input bit dn);
    int t = p;
    if (up && !dn)      t -= PSTEP;
    else if (dn && !up) t += PSTEP;
    if (t < 0)    t = 0;
    if (t > PMAX) t = PMAX;
    return t;
  endfunction

  task automatic bump();
`ifdef PONG_SPEEDUP_EN
    if (m_step < 2 * BSTEP) m_step++;
`endif
  endtask

  task automatic model_tick(input bit u1, input bit d1, input bit u2, input bit d2);
    bit pend, ov1, ov2, hl, hr;
    int nx, ny;
    pend = m_pend; m_pend = 0;
    case (m_st)
      0: if (pend) begin
        m_st = 1; m_cnt = 0; m_s1 = 0; m_s2 = 0; m_dx = 1; m_dy = 1; m_step = BSTEP;
      end
      1: begin
        m_p1 = mv(m_p1, u1, d1); m_p2 = mv(m_p2, u2, d2);
        m_cnt++;
        if (m_cnt == SERVE_N - 1) m_st = 2;
      end
      2: begin
        nx  = m_bx + (m_dx ? m_step : -m_step);
        ny  = m_by + (m_dy ? m_step : -m_step);
        ov1 = (m_by + 8 > m_p1) && (m_by < m_p1 + 64);
        ov2 = (m_by + 8 > m_p2) && (m_by < m_p2 + 64);
        hl  = !m_dx && m_bx >= 24 && nx <= 24 && ov1;
        hr  = m_dx && m_bx + 8 <= 616 && nx + 8 >= 616 && ov2;
        m_p1 = mv(m_p1, u1, d1); m_p2 = mv(m_p2, u2, d2);
        if (hl)      begin m_bx = 24;  m_dx = 1; bump(); end
        else if (hr) begin m_bx = 608; m_dx = 0; bump(); end
        else if (nx <= 0 || nx + 8 >= 640) begin m_st = 3; m_p1_scored = (nx > 0); end
        else m_bx = nx;
        if (m_st == 2) begin
          if (!m_dy && ny <= 0)            begin m_by = 0;   m_dy = 1; end
          else if (m_dy && ny + 8 >= 480)  begin m_by = 472; m_dy = 0; end
          else m_by = ny;
        end
      end
      3: begin
        if (m_p1_scored) m_s1++; else m_s2++;
        if (m_s1 == WIN || m_s2 == WIN) begin
          m_st = 4; m_win = m_p1_scored ? 1 : 2;
        end else begin
          m_st = 1; m_cnt = 0; m_bx = 316; m_by = 236; m_dx = m_p1_scored; m_dy = 1; m_step = BSTEP;
        end
      end
      default: if (pend) begin
        m_st = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_p1 = 208; m_p2 = 208;
        m_bx = 316; m_by = 236; m_dx = 1; m_dy = 1;
      end
    endcase
  endtask

  task automatic do_tick(input bit u1, input bit d1, input bit u2, input bit d2, input string tag);
    int prev = m_st;
    @(negedge clk);
    p1_up = u1; p1_down = d1; p2_up = u2; p2_down = d2; frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    model_tick(u1, d1, u2, d2);
    check_all(tag);
    n_tick++;
    if (m_st != prev)
      $display("tick %0d %s: state %0d->%0d score %0d:%0d ball (%0d,%0d) paddles %0d/%0d",
               n_tick, tag, prev, m_st, m_s1, m_s2, m_bx, m_by, m_p1, m_p2);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    m_pend = 1;
  endtask

  function automatic bit [1:0] track(input int p);
    if (p + 32 > m_by + 6)      return 2'b10;
    else if (p + 32 < m_by + 2) return 2'b01;
    return 2'b00;
  endfunction

  initial begin
    bit [1:0] a, b;
    bit seen_bot;
    seen_bot = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    chk("reset.paddle_const", paddle_1, 208);
    chk("reset.ball_x_const", ball_x, 316);
    chk("reset.ball_y_const", ball_y, 236);
    reset = 1'b1;
    @(negedge clk);

    pulse_start();
    do_tick(0, 0, 0, 0, "start");
    chk("serve.entry", state, 1);
    for (int i = 1; i <= SERVE_N - 1; i++) begin
      do_tick(1, 0, 0, 0, "p1_up");
      if (i == 52) chk("p1_top_after_52", paddle_1, 0);
    end
    chk("launch.state", state, 2);
    chk("launch.ball_x", ball_x, 316);
    chk("launch.ball_y", ball_y, 236);
    do_tick(1, 0, 0, 0, "first_play");
    chk("first_play.ball_x", ball_x, 318);
    chk("first_play.ball_y", ball_y, 238);
    chk("p1_stays_top", paddle_1, 0);
    do_tick(1, 1, 1, 1, "both_pressed");
    chk("both.paddle_1", paddle_1, 0);
    chk("both.paddle_2", paddle_2, 208);

    for (int k = 0; k < 400 && m_st == 2; k++) begin
      do_tick(0, 0, 1, 0, "p2_high");
      if (ball_y == 12'd472) seen_bot = 1;
    end
    chk("bottom_wall_seen", seen_bot, 1);
    chk("miss.state", state, 3);
    do_tick(0, 0, 0, 0, "point");
    chk("point.score_1", score_1, 1);
    chk("point.state", state, 1);
    chk("point.ball_x", ball_x, 316);

    for (int k = 0; k < 600; k++) begin
      b = track(m_p2);
      do_tick(0, 0, b[1], b[0], "p2_track");
      if (m_st == 2 && m_bx == 608 && !m_dx) break;
    end
    chk("hit_r.ball_x", ball_x, 608);
    chk("hit_r.score_1", score_1, 1);
    chk("hit_r.score_2", score_2, 0);

    for (int k = 0; k < 8000 && m_st != 4; k++) begin
      if ($urandom_range(0, 19) == 0) pulse_start();
      a = track(m_p1);
      b = ($urandom_range(0, 3) == 0) ? track(m_p2) : 2'($urandom_range(0, 3));
      do_tick(a[1], a[0], b[1], b[0], "rally");
    end
    chk("over.state", state, 4);
    chk("over.winner", winner, m_win);
    for (int k = 0; k < 5; k++) do_tick(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), "over_hold");
    pulse_start();
    do_tick(0, 0, 0, 0, "restart");
    chk("restart.state", state, 0);
    chk("restart.score_1", score_1, 0);
    chk("restart.score_2", score_2, 0);
    chk("restart.winner", winner, 0);

    pulse_start();
    for (int k = 0; k < SERVE_N + 3; k++)
      do_tick(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), "replay");
    chk("replay.state", state, 2);
    for (int k = 0; k < 10; k++) begin
      repeat (100) @(negedge clk);
      check_all("no_tick_hold");
    end
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_reset.state", state, 0);
    chk("async_reset.paddle_1", paddle_1, 208);
    chk("async_reset.paddle_2", paddle_2, 208);
    chk("async_reset.ball_x", ball_x, 316);
    chk("async_reset.ball_y", ball_y, 236);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    check_all("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
